// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: a single FSM steps each instruction through
// fetch, decode, execute, memory and writeback. It drives the shared-datapath
// control signals as a combinational decode of the current state, plus OP/Funct.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-high reset
//   OP, Funct          IR[31:26] and IR[5:0]; the IR is valid from DECODE onward
//   mem_ready          memory access completes this cycle
//   PCWrite, BranchEQ, BranchNE, PCSource   PC update control
//   IorD, MemRead, MemWrite, IRWrite        unified memory / IR control
//   MemtoReg, RegDst, RegWrite              register-file writeback control
//   ALUSrcA, ALUSrcB, ALUOp                 ALU operand and operation select
//   illegal_op         one-cycle pulse in DECODE for an undecodable instruction
//   state_o            current state encoding, for debug
module mips_multicycle_control #(
    parameter int unsigned ALUOP_W = 3,
    parameter bit          JAL_EN  = 1'b1,
    parameter bit          WAIT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OP,
    input  logic [5:0]         Funct,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               BranchEQ,
    output logic               BranchNE,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic [3:0]         state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        R_EXEC   = 4'd2,
        R_WB     = 4'd3,
        I_EXEC   = 4'd4,
        I_WB     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        JAL_ST   = 4'd12,
        JR       = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b111;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_AND   = 3'b110;
    localparam logic [2:0] ALU_LUI   = 3'b010;

    state_t     state;
    state_t     stateNext;
    logic [2:0] aluOp3;
    logic       memDone;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    // Memory completion. Gated by reset so that FETCH shows no IR/PC load while reset is held.
    assign memDone = (mem_ready || !WAIT_EN) && !reset;

    // Next-state and control decode
    always_comb begin
        stateNext  = state;
        PCWrite    = 1'b0;
        BranchEQ   = 1'b0;
        BranchNE   = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 2'd0;
        RegDst     = 2'd0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'd0;
        aluOp3     = 3'b000;
        PCSource   = 2'd0;
        illegal_op = 1'b0;

        case (state)
            FETCH: begin
                MemRead = 1'b1;
                if (memDone) begin
                    IRWrite   = 1'b1;
                    ALUSrcB   = 2'd1;
                    aluOp3    = ALU_ADD;
                    PCWrite   = 1'b1;
                    stateNext = DECODE;
                end
            end
            DECODE: begin
                // Branch target is precomputed here while the instruction is classified
                ALUSrcB = 2'd2;
                aluOp3  = ALU_ADD;
                case (OP)
                    OP_RTYPE: begin
                        if (Funct != FN_JR) begin
                            stateNext = R_EXEC;
                        end else if (JAL_EN) begin
                            stateNext = JR;
                        end else begin
                            stateNext  = FETCH;
                            illegal_op = 1'b1;
                        end
                    end
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: stateNext = I_EXEC;
                    OP_LW, OP_SW:                     stateNext = MEM_ADDR;
                    OP_BEQ, OP_BNE:                   stateNext = BRANCH;
                    OP_J:                             stateNext = JUMP;
                    OP_JAL: begin
                        if (JAL_EN) begin
                            stateNext = JAL_ST;
                        end else begin
                            stateNext  = FETCH;
                            illegal_op = 1'b1;
                        end
                    end
                    default: begin
                        stateNext  = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            R_EXEC: begin
                ALUSrcA   = 1'b1;
                aluOp3    = ALU_RTYPE;
                stateNext = R_WB;
            end
            R_WB: begin
                RegDst    = 2'd1;
                RegWrite  = 1'b1;
                stateNext = FETCH;
            end
            I_EXEC: begin
                ALUSrcA = 1'b1;
                case (OP)
                    OP_ORI: begin
                        ALUSrcB = 2'd3;
                        aluOp3  = ALU_OR;
                    end
                    OP_ANDI: begin
                        ALUSrcB = 2'd3;
                        aluOp3  = ALU_AND;
                    end
                    OP_LUI: begin
                        ALUSrcB = 2'd3;
                        aluOp3  = ALU_LUI;
                    end
                    default: begin
                        ALUSrcB = 2'd2;
                        aluOp3  = ALU_ADD;
                    end
                endcase
                stateNext = I_WB;
            end
            I_WB: begin
                RegWrite  = 1'b1;
                stateNext = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                aluOp3    = ALU_ADD;
                stateNext = (OP == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (memDone) begin
                    stateNext = MEM_WB;
                end
            end
            MEM_WB: begin
                MemtoReg  = 2'd1;
                RegWrite  = 1'b1;
                stateNext = FETCH;
            end
            MEM_WR: begin
                // Held every wait cycle; memory commits only on the ready cycle
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (memDone) begin
                    stateNext = FETCH;
                end
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                aluOp3    = ALU_SUB;
                PCSource  = 2'd1;
                BranchEQ  = (OP == OP_BEQ);
                BranchNE  = (OP == OP_BNE);
                stateNext = FETCH;
            end
            JUMP: begin
                PCSource  = 2'd2;
                PCWrite   = 1'b1;
                stateNext = FETCH;
            end
            JAL_ST: begin
                // PC already holds PC+4, so it is the link value
                RegDst    = 2'd2;
                MemtoReg  = 2'd2;
                RegWrite  = 1'b1;
                PCSource  = 2'd2;
                PCWrite   = 1'b1;
                stateNext = FETCH;
            end
            JR: begin
                PCSource  = 2'd3;
                PCWrite   = 1'b1;
                stateNext = FETCH;
            end
            default: stateNext = FETCH;
        endcase
    end

    assign ALUOp   = ALUOP_W'(aluOp3);
    assign state_o = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control. Three configurations run side by side:
//   dut0: WAIT_EN=1, JAL_EN=1   dut1: WAIT_EN=0, JAL_EN=1   dut2: WAIT_EN=0, JAL_EN=0
// Each instruction is expanded into its expected per-cycle control trace from
// the instruction class and the memory wait counts, then replayed and compared.
module tb_mips_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, beq, bne, iord, mrd, mwr, irw;
        logic [1:0] m2r, rdst;
        logic       rw, srca;
        logic [1:0] srcb;
        logic [2:0] aop;
        logic [1:0] pcs;
        logic       ill;
    } ctrl_t;

    localparam logic [2:0] A_ADD = 3'b100, A_SUB = 3'b001, A_RT = 3'b111;
    localparam logic [2:0] A_OR  = 3'b101, A_AND = 3'b110, A_LUI = 3'b010;

    logic       clk = 1'b0;
    logic       rstIn   [3];
    logic [5:0] opIn    [3];
    logic [5:0] functIn [3];
    logic       rdyIn   [3];
    ctrl_t      obs     [3];

    int nChecks = 0;
    int nFail   = 0;
    int irwCount, pcwCount, rwCount;

    ctrl_t expQ[$];
    int    rdyQ[$];   // 0 = drive low, 1 = drive high, 2 = random (ignored by DUT)
    bit    opValidQ[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        logic       pcWrite, branchEq, branchNe, iorD, memRead, memWrite, irWrite;
        logic [1:0] memtoReg, regDst, aluSrcB, pcSource;
        logic       regWrite, aluSrcA, illegalOp;
        logic [2:0] aluOp;
        logic [3:0] stateO;

        mips_multicycle_control #(
            .ALUOP_W (3),
            .JAL_EN  ((g == 2) ? 1'b0 : 1'b1),
            .WAIT_EN ((g == 0) ? 1'b1 : 1'b0)
        ) dut (
            .clk        (clk),
            .reset      (rstIn[g]),
            .OP         (opIn[g]),
            .Funct      (functIn[g]),
            .mem_ready  (rdyIn[g]),
            .PCWrite    (pcWrite),
            .BranchEQ   (branchEq),
            .BranchNE   (branchNe),
            .IorD       (iorD),
            .MemRead    (memRead),
            .MemWrite   (memWrite),
            .IRWrite    (irWrite),
            .MemtoReg   (memtoReg),
            .RegDst     (regDst),
            .RegWrite   (regWrite),
            .ALUSrcA    (aluSrcA),
            .ALUSrcB    (aluSrcB),
            .ALUOp      (aluOp),
            .PCSource   (pcSource),
            .illegal_op (illegalOp),
            .state_o    (stateO)
        );

        assign obs[g] = {stateO, pcWrite, branchEq, branchNe, iorD, memRead, memWrite,
                         irWrite, memtoReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
                         pcSource, illegalOp};
    end

    function automatic ctrl_t fetchIdle();
        ctrl_t c = '0;
        c.mrd = 1'b1;
        return c;
    endfunction

    // Instruction class: 0 illegal, 1 R, 2 I, 3 LW, 4 SW, 5 branch, 6 J, 7 JAL, 8 JR
    function automatic int classify(logic [5:0] op, logic [5:0] fn, bit jalEn);
        case (op)
            6'h00:                      return (fn == 6'h08) ? (jalEn ? 8 : 0) : 1;
            6'h08, 6'h0c, 6'h0d, 6'h0f: return 2;
            6'h23:                      return 3;
            6'h2b:                      return 4;
            6'h04, 6'h05:               return 5;
            6'h02:                      return 6;
            6'h03:                      return jalEn ? 7 : 0;
            default:                    return 0;
        endcase
    endfunction

    task automatic pushStep(input ctrl_t c, input int r, input bit v);
        expQ.push_back(c);
        rdyQ.push_back(r);
        opValidQ.push_back(v);
    endtask

    // Builds and replays one instruction; called and returns at a falling edge.
    task automatic runInstr(input string name, input int d, input logic [5:0] op,
                            input logic [5:0] fn, input int fw, input int mw,
                            input int abortAfter);
        bit    waitEn = (d == 0);
        bit    jalEn  = (d != 2);
        int    cls;
        int    goRdy;
        ctrl_t c;
        expQ.delete(); rdyQ.delete(); opValidQ.delete();
        if (!waitEn) begin fw = 0; mw = 0; end
        goRdy = waitEn ? 1 : 2;
        cls   = classify(op, fn, jalEn);

        repeat (fw) pushStep(fetchIdle(), 0, 1'b0);
        c = fetchIdle(); c.irw = 1; c.srcb = 2'd1; c.aop = A_ADD; c.pcw = 1;
        pushStep(c, goRdy, 1'b0);
        c = '0; c.st = 4'd1; c.srcb = 2'd2; c.aop = A_ADD; c.ill = (cls == 0);
        pushStep(c, 2, 1'b1);
        case (cls)
            1: begin
                c = '0; c.st = 4'd2; c.srca = 1; c.aop = A_RT; pushStep(c, 2, 1'b1);
                c = '0; c.st = 4'd3; c.rdst = 2'd1; c.rw = 1; pushStep(c, 2, 1'b1);
            end
            2: begin
                c = '0; c.st = 4'd4; c.srca = 1;
                case (op)
                    6'h08:   begin c.srcb = 2'd2; c.aop = A_ADD; end
                    6'h0d:   begin c.srcb = 2'd3; c.aop = A_OR;  end
                    6'h0c:   begin c.srcb = 2'd3; c.aop = A_AND; end
                    default: begin c.srcb = 2'd3; c.aop = A_LUI; end
                endcase
                pushStep(c, 2, 1'b1);
                c = '0; c.st = 4'd5; c.rw = 1; pushStep(c, 2, 1'b1);
            end
            3, 4: begin
                c = '0; c.st = 4'd6; c.srca = 1; c.srcb = 2'd2; c.aop = A_ADD;
                pushStep(c, 2, 1'b1);
                c = '0; c.iord = 1;
                if (cls == 3) begin c.st = 4'd7; c.mrd = 1; end
                else          begin c.st = 4'd9; c.mwr = 1; end
                repeat (mw) pushStep(c, 0, 1'b1);
                pushStep(c, goRdy, 1'b1);
                if (cls == 3) begin
                    c = '0; c.st = 4'd8; c.m2r = 2'd1; c.rw = 1; pushStep(c, 2, 1'b1);
                end
            end
            5: begin
                c = '0; c.st = 4'd10; c.srca = 1; c.aop = A_SUB; c.pcs = 2'd1;
                c.beq = (op == 6'h04); c.bne = (op == 6'h05);
                pushStep(c, 2, 1'b1);
            end
            6: begin c = '0; c.st = 4'd11; c.pcs = 2'd2; c.pcw = 1; pushStep(c, 2, 1'b1); end
            7: begin
                c = '0; c.st = 4'd12; c.rdst = 2'd2; c.m2r = 2'd2; c.rw = 1;
                c.pcs = 2'd2; c.pcw = 1;
                pushStep(c, 2, 1'b1);
            end
            8: begin c = '0; c.st = 4'd13; c.pcs = 2'd3; c.pcw = 1; pushStep(c, 2, 1'b1); end
            default: ;
        endcase

        for (int k = 0; k < expQ.size(); k++) begin
            if (abortAfter >= 0 && k == abortAfter) return;
            opIn[d]    = opValidQ[k] ? op : 6'($urandom);
            functIn[d] = opValidQ[k] ? fn : 6'($urandom);
            rdyIn[d]   = (rdyQ[k] == 2) ? 1'($urandom) : 1'(rdyQ[k]);
            #1;
            nChecks++;
            if (obs[d] !== expQ[k]) begin
                nFail++;
                $display("FAIL %s dut%0d cycle %0d: got state %0d ctrl %h, want state %0d ctrl %h",
                         name, d, k, obs[d].st, obs[d], expQ[k].st, expQ[k]);
            end
            if (obs[d].irw) irwCount++;
            if (obs[d].pcw) pcwCount++;
            if (obs[d].rw)  rwCount++;
            @(negedge clk);
        end
    endtask

    // Holds every instance in reset, then releases only instance d at a falling edge.
    task automatic doReset(input int d);
        @(negedge clk);
        for (int i = 0; i < 3; i++) rstIn[i] = 1'b1;
        rdyIn[d] = 1'b0;
        @(negedge clk);
        rstIn[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rstIn[i] = 1'b1; rdyIn[i] = 1'b1; opIn[i] = 6'h23; functIn[i] = 6'h20;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            nChecks++;
            if (obs[i] !== fetchIdle()) begin
                nFail++;
                $display("FAIL reset_hold dut%0d: got %h want %h", i, obs[i], fetchIdle());
            end
        end
        @(negedge clk);
        rdyIn[0] = 1'b0; rstIn[0] = 1'b0;
        #1;
        nChecks++;
        if (obs[0] !== fetchIdle()) begin
            nFail++;
            $display("FAIL reset_release: got %h want %h", obs[0], fetchIdle());
        end
    endtask

    task automatic test_rtype();
        doReset(1);
        rwCount = 0;
        runInstr("rtype_add", 1, 6'h00, 6'h20, 0, 0, -1);
        nChecks++;
        if (rwCount !== 1) begin
            nFail++;
            $display("FAIL rtype_regwrite_count: got %0d want 1", rwCount);
        end
    endtask

    task automatic test_lw_wait();
        doReset(0);
        irwCount = 0; pcwCount = 0;
        runInstr("lw_wait", 0, 6'h23, 6'h11, 2, 2, -1);
        nChecks++;
        if (irwCount !== 1 || pcwCount !== 1) begin
            nFail++;
            $display("FAIL lw_pulses: got IRWrite %0d PCWrite %0d want 1 and 1", irwCount, pcwCount);
        end
    endtask

    task automatic test_jal();
        doReset(1);
        runInstr("jal", 1, 6'h03, 6'h00, 0, 0, -1);
        doReset(2);
        runInstr("jal_disabled", 2, 6'h03, 6'h00, 0, 0, -1);
        runInstr("after_illegal", 2, 6'h02, 6'h00, 0, 0, -1);
    endtask

    task automatic test_branch_ori();
        doReset(1);
        runInstr("bne", 1, 6'h05, 6'h3f, 0, 0, -1);
        runInstr("beq", 1, 6'h04, 6'h00, 0, 0, -1);
        runInstr("ori", 1, 6'h0d, 6'h00, 0, 0, -1);
    endtask

    task automatic test_jr();
        doReset(1);
        rwCount = 0;
        runInstr("jr", 1, 6'h00, 6'h08, 0, 0, -1);
        nChecks++;
        if (rwCount !== 0) begin
            nFail++;
            $display("FAIL jr_no_regwrite: got %0d RegWrite cycles want 0", rwCount);
        end
        doReset(2);
        runInstr("jr_disabled", 2, 6'h00, 6'h08, 0, 0, -1);
    endtask

    task automatic test_async_reset();
        doReset(0);
        runInstr("sw_abort", 0, 6'h2b, 6'h00, 0, 3, 4);
        rdyIn[0] = 1'b0;
        #1;
        nChecks++;
        if (obs[0].st !== 4'd9 || obs[0].mwr !== 1'b1) begin
            nFail++;
            $display("FAIL pre_abort_memwr: got state %0d MemWrite %b want 9 and 1", obs[0].st, obs[0].mwr);
        end
        rdyIn[0] = 1'b1;
        rstIn[0] = 1'b1;
        #1;
        nChecks++;
        if (obs[0] !== fetchIdle()) begin
            nFail++;
            $display("FAIL async_reset: got state %0d ctrl %h want %h", obs[0].st, obs[0], fetchIdle());
        end
        @(negedge clk);
        rdyIn[0] = 1'b0;
        rstIn[0] = 1'b0;
        runInstr("after_abort", 0, 6'h08, 6'h00, 1, 0, -1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [12];
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h00};
        for (int d = 0; d < 3; d++) begin
            doReset(d);
            for (int n = 0; n < 40; n++) begin
                logic [5:0] op;
                logic [5:0] fn;
                op = ops[$urandom_range(0, 11)];
                if ($urandom_range(0, 7) == 0) op = 6'($urandom);
                fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
                runInstr("random", d, op, fn, $urandom_range(0, 3), $urandom_range(0, 3), -1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_jal();
        test_branch_ori();
        test_jr();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Parametrised multicycle successor to the single-cycle MIPS decoder.
- One FSM sequences each instruction through fetch, decode, execute, memory and writeback, and drives the shared-datapath control signals once per state.
- Adds JAL/JR support, a memory-ready wait handshake and an illegal-opcode flag.
- Sits between instruction register/memory and the multicycle datapath (PC, IR, register file, ALU, unified memory).

Parameters:
- ALUOP_W, 3, width of ALUOp bus; codes are zero-extended to this width (minimum 3).
- JAL_EN, 1, 1 = decode JAL (op 0x03) and JR (R-type funct 0x08); 0 = treat both as illegal.
- WAIT_EN, 1, 1 = memory states hold until mem_ready; 0 = mem_ready is ignored and memory takes one cycle.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- OP  in  6  instruction opcode, IR[31:26]; IR is valid from DECODE onward
- Funct  in  6  IR[5:0]
- mem_ready  in  1  memory access complete this cycle
- PCWrite  out  1  unconditional PC load
- BranchEQ  out  1  PC load if ALU zero
- BranchNE  out  1  PC load if not zero
- IorD  out  1  0 = memory address from PC, 1 = from ALUOut
- MemRead  out  1  memory read
- MemWrite  out  1  memory write
- IRWrite  out  1  IR load
- MemtoReg  out  2  writeback source: 0 = ALUOut, 1 = MDR, 2 = PC (link)
- RegDst  out  2  destination register: 0 = rt, 1 = rd, 2 = r31
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = zero-extended imm
- ALUOp  out  ALUOP_W  ADD=100, SUB=001, RTYPE=111, OR=101, AND=110, LUI=010
- PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs (JR)
- illegal_op  out  1  one-cycle pulse on undecodable opcode
- state_o  out  4  current state encoding, for debug

Behaviour:
- Registered state; all outputs are a combinational decode of state plus OP/Funct (Moore-style except the DECODE branch and JR selection).
- Every output not listed as asserted in a state is 0.
- Reset (asynchronous, active-high): state = FETCH immediately; all outputs reflect FETCH with mem_ready low, i.e. MemRead=1, IorD=0, everything else 0; illegal_op=0.
- Reset mid-instruction aborts the instruction with no further writes.
- FETCH (0): MemRead=1, IorD=0.
  - When the access completes (mem_ready=1, or always when WAIT_EN=0): IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0, PCWrite=1.
  - Then go to DECODE. Otherwise stay in FETCH with IRWrite=PCWrite=0.
- DECODE (1): ALUSrcA=0, ALUSrcB=2 (branch target precompute), ALUOp=ADD. Next state by OP:
  - R-type with Funct=0x08 and JAL_EN=1 -> JR.
  - Other R-type -> R_EXEC.
  - ADDI/ORI/ANDI/LUI -> I_EXEC.
  - LW/SW -> MEM_ADDR.
  - BEQ/BNE -> BRANCH.
  - J -> JUMP.
  - JAL (JAL_EN=1) -> JAL_ST.
  - Anything else -> FETCH with illegal_op=1 for that cycle.
- R_EXEC (2): ALUSrcA=1, ALUSrcB=0, ALUOp=RTYPE -> R_WB.
- R_WB (3): RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- I_EXEC (4): ALUSrcA=1. ALUSrcB=2 for ADDI, 3 for ORI/ANDI/LUI. ALUOp = ADD/OR/AND/LUI respectively -> I_WB.
- I_WB (5): RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- MEM_ADDR (6): ALUSrcA=1, ALUSrcB=2, ALUOp=ADD -> MEM_RD for LW, MEM_WR for SW.
- MEM_RD (7): MemRead=1, IorD=1. Hold until ready, then -> MEM_WB.
- MEM_WB (8): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEM_WR (9): MemWrite=1, IorD=1, held every cycle until ready, then -> FETCH. No duplicate side effect is permitted: memory commits the write on the ready cycle only.
- BRANCH (10): ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1. BranchEQ=1 for BEQ, BranchNE=1 for BNE -> FETCH.
- JUMP (11): PCSource=2, PCWrite=1 -> FETCH.
- JAL_ST (12): RegDst=2, MemtoReg=2, RegWrite=1, PCSource=2, PCWrite=1 -> FETCH. PC still holds PC+4 at this point, so the link value is correct.
- JR (13): PCSource=3, PCWrite=1 -> FETCH.
- Unused encodings 14-15 -> FETCH, outputs 0.
- Cycle counts with WAIT_EN=0:
  - 3 cycles: BEQ, BNE, J, JAL, JR.
  - 4 cycles: R-type, I-type, SW.
  - 5 cycles: LW.
  - Each memory wait cycle adds 1.
- mem_ready asserted outside FETCH/MEM_RD/MEM_WR is ignored.

Test Plan:
- Reset asserted asynchronously mid MEM_WR -> state_o=0 and MemWrite=0 immediately, without waiting for a clock edge. After release: MemRead=1, IorD=0.
- WAIT_EN=0, OP=0x00, Funct=0x20 -> state sequence 0,1,2,3,0. RegWrite=1 only in state 3 with RegDst=1. ALUOp=111 in state 2.
- WAIT_EN=1, OP=0x23 (LW), mem_ready low for 2 cycles in both FETCH and MEM_RD -> 9 cycles total. IRWrite and PCWrite pulse exactly once. MEM_WB has MemtoReg=1.
- OP=0x03 (JAL), JAL_EN=1 -> in state 12: RegDst=2, MemtoReg=2, RegWrite=1, PCSource=2, PCWrite=1. Same OP with JAL_EN=0 -> illegal_op pulses 1 cycle in DECODE, then FETCH.
- OP=0x05 (BNE) -> BRANCH with BranchNE=1, BranchEQ=0, ALUOp=001, ALUSrcB=0. OP=0x0d (ORI) -> I_EXEC with ALUSrcB=3, ALUOp=101.
- OP=0x00, Funct=0x08 (JR) -> states 0,1,13. PCSource=3 and PCWrite=1 in state 13. RegWrite never asserted.
